// File: rtl/trellis_bidir_io.sv
// Bidirectional pad cell after the ECP5 TRELLIS_IO primitive: WIDTH bits, one shared
// tri-state control, optional registered capture (IN_REG) and output/enable registers (OUT_REG).
module trellis_bidir_io #(
    parameter string DIR     = "BIDIR",
    parameter int    WIDTH   = 8,
    parameter bit    IN_REG  = 1'b0,
    parameter bit    OUT_REG = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    inout  wire  [WIDTH-1:0] B,
    input  logic             T,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O
);

    logic             t_eff;
    logic [WIDTH-1:0] i_eff;

    // Clock, reset and controls go unused in some configurations; collect them so they stay visible.
    wire unused_inputs = &{1'b0, clk_i, reset_i, T, I, t_eff, i_eff};

    generate
        if (OUT_REG) begin : g_out_reg
            logic             t_q;
            logic [WIDTH-1:0] i_q;

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    t_q <= 1'b1;
                    i_q <= '0;
                end else begin
                    t_q <= T;
                    i_q <= I;
                end
            end

            assign t_eff = t_q;
            assign i_eff = i_q;
        end else begin : g_out_comb
            assign t_eff = T;
            assign i_eff = I;
        end
    endgenerate

    generate
        if (DIR == "BIDIR") begin : g_bidir
            assign B = t_eff ? {WIDTH{1'bz}} : i_eff;
        end else if (DIR == "OUTPUT") begin : g_output
            assign B = i_eff;
        end else if (DIR == "INPUT") begin : g_input
            assign B = {WIDTH{1'bz}};
        end else begin : g_bad_dir
            $error("trellis_bidir_io: DIR must be INPUT, OUTPUT or BIDIR");
        end
    endgenerate

    // The receive path always watches the pad itself, so a driving cell sees its own loopback.
    generate
        if (IN_REG) begin : g_in_reg
            logic [WIDTH-1:0] o_q;

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    o_q <= '0;
                end else begin
                    o_q <= B;
                end
            end

            assign O = o_q;
        end else begin : g_in_comb
            assign O = B;
        end
    endgenerate

endmodule

// File: tb/tb_trellis_bidir_io.sv
// Self-checking bench for trellis_bidir_io: several configurations side by side, directed
// steps followed by randomized traffic compared against a cycle-level model of the pad.
module tb_trellis_bidir_io;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // BIDIR, combinational
    logic       t_c = 1'b1;
    logic [7:0] i_c = '0;
    logic [7:0] ext_c = '0;
    logic       ext_c_en = 1'b0;
    wire  [7:0] bus_c;
    logic [7:0] o_c;
    assign bus_c = ext_c_en ? ext_c : 8'hzz;

    // BIDIR, registered in and out
    logic       t_r = 1'b0;
    logic [7:0] i_r = '0;
    logic [7:0] ext_r = '0;
    logic       ext_r_en = 1'b0;
    wire  [7:0] bus_r;
    logic [7:0] o_r;
    assign bus_r = ext_r_en ? ext_r : 8'hzz;

    // INPUT and OUTPUT modes share the combinational controls
    logic [7:0] ext_n = '0;
    wire  [7:0] bus_n;
    logic [7:0] o_n;
    assign bus_n = ext_n;
    wire  [7:0] bus_o;
    logic [7:0] o_o;

    // 16-bit BIDIR, combinational
    logic        t_w = 1'b1;
    logic [15:0] i_w = '0;
    logic [15:0] ext_w = '0;
    logic        ext_w_en = 1'b0;
    wire  [15:0] bus_w;
    logic [15:0] o_w;
    assign bus_w = ext_w_en ? ext_w : 16'hzzzz;

    trellis_bidir_io #(.DIR("BIDIR"), .WIDTH(8)) u_comb (
        .clk_i(clock), .reset_i(reset), .B(bus_c), .T(t_c), .I(i_c), .O(o_c));
    trellis_bidir_io #(.DIR("BIDIR"), .WIDTH(8), .IN_REG(1'b1), .OUT_REG(1'b1)) u_reg (
        .clk_i(clock), .reset_i(reset), .B(bus_r), .T(t_r), .I(i_r), .O(o_r));
    trellis_bidir_io #(.DIR("INPUT"), .WIDTH(8)) u_in (
        .clk_i(clock), .reset_i(reset), .B(bus_n), .T(t_c), .I(i_c), .O(o_n));
    trellis_bidir_io #(.DIR("OUTPUT"), .WIDTH(8)) u_out (
        .clk_i(clock), .reset_i(reset), .B(bus_o), .T(t_c), .I(i_c), .O(o_o));
    trellis_bidir_io #(.DIR("BIDIR"), .WIDTH(16)) u_wide (
        .clk_i(clock), .reset_i(reset), .B(bus_w), .T(t_w), .I(i_w), .O(o_w));

    // Model of the registered cell: what the pad drives this cycle and what O shows.
    logic       m_released = 1'b1;
    logic [7:0] m_drive    = '0;
    logic [7:0] m_seen     = '0;
    logic [7:0] m_bus      = '0;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            $error("[TB] %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock of the registered cell. The bench only drives the bus while the model says
    // the cell has let go, so any contention shows up as a wrong bus value.
    task automatic applyStimulus(input logic [7:0] new_ext);
        @(posedge clock);
        m_seen     = reset ? 8'h00 : m_bus;
        m_released = reset ? 1'b1  : t_r;
        m_drive    = reset ? 8'h00 : i_r;
        #1;
        ext_r    = new_ext;
        ext_r_en = m_released;
        #1;
        m_bus = m_released ? ext_r : m_drive;
    endtask

    task automatic checkRegistered(input string tag);
        checkOutput({tag, "_bus"}, {8'h00, bus_r}, {8'h00, m_bus});
        checkOutput({tag, "_o"},   {8'h00, o_r},   {8'h00, m_seen});
    endtask

    initial begin
        // Combinational BIDIR: drive, then release to an external source
        t_c = 1'b0; i_c = 8'hA5; ext_c_en = 1'b0;
        #1;
        checkOutput("comb_drive_bus", {8'h00, bus_c}, 16'h00A5);
        checkOutput("comb_drive_o",   {8'h00, o_c},   16'h00A5);
        t_c = 1'b1; ext_c = 8'h3C; ext_c_en = 1'b1;
        #1;
        checkOutput("comb_release_bus", {8'h00, bus_c}, 16'h003C);
        checkOutput("comb_release_o",   {8'h00, o_c},   16'h003C);

        // INPUT ignores T/I; OUTPUT ignores T
        t_c = 1'b0; i_c = 8'hAA; ext_n = 8'h0F; ext_c_en = 1'b0;
        #1;
        checkOutput("input_bus", {8'h00, bus_n}, 16'h000F);
        checkOutput("input_o",   {8'h00, o_n},   16'h000F);
        t_c = 1'b1; i_c = 8'h81; ext_c_en = 1'b1;
        #1;
        checkOutput("output_bus", {8'h00, bus_o}, 16'h0081);
        checkOutput("output_o",   {8'h00, o_o},   16'h0081);

        // 16-bit drive
        t_w = 1'b0; i_w = 16'hBEEF;
        #1;
        checkOutput("wide_bus", bus_w, 16'hBEEF);
        checkOutput("wide_o",   o_w,   16'hBEEF);

        // Registered cell: two reset cycles keep the pad released and O cleared
        reset = 1'b1; t_r = 1'b0; i_r = 8'hEE;
        applyStimulus(8'h77);
        checkRegistered("reset1");
        applyStimulus(8'h77);
        checkRegistered("reset2");

        // Drive appears one edge later, loopback on O one edge after that
        reset = 1'b0; t_r = 1'b0; i_r = 8'h5A;
        applyStimulus(8'h77);
        checkRegistered("drive_edge1");
        applyStimulus(8'h77);
        checkRegistered("drive_edge2");
        checkOutput("drive_loopback", {8'h00, o_r}, 16'h005A);

        // Turnaround: drive FF, then release and let the outside drive 11
        i_r = 8'hFF;
        applyStimulus(8'h00);
        checkRegistered("turn_drive");
        t_r = 1'b1;
        applyStimulus(8'h11);
        checkRegistered("turn_release");
        checkOutput("turn_release_val", {8'h00, bus_r}, 16'h0011);
        applyStimulus(8'h11);
        checkRegistered("turn_after");

        // Reset asserted mid-drive releases the pad until reset drops and T goes low
        t_r = 1'b0; i_r = 8'hC3;
        applyStimulus(8'h00);
        checkRegistered("middrive_drive");
        reset = 1'b1;
        applyStimulus(8'h22);
        checkRegistered("middrive_reset1");
        applyStimulus(8'h22);
        checkRegistered("middrive_reset2");
        reset = 1'b0; t_r = 1'b1;
        applyStimulus(8'h44);
        checkRegistered("middrive_held");
        t_r = 1'b0;
        applyStimulus(8'h44);
        checkRegistered("middrive_resume");

        // Random traffic on the registered cell, with occasional resets
        for (int n = 0; n < 200; n++) begin
            reset = ($urandom_range(0, 15) == 0);
            t_r   = $urandom_range(0, 1) == 1;
            i_r   = 8'($urandom);
            applyStimulus(8'($urandom));
            checkRegistered("rand_reg");
        end

        // Random traffic on the combinational cells
        reset = 1'b0;
        for (int n = 0; n < 50; n++) begin
            t_c   = $urandom_range(0, 1) == 1;
            i_c   = 8'($urandom);
            ext_c = 8'($urandom);
            ext_n = 8'($urandom);
            ext_c_en = t_c;
            t_w   = $urandom_range(0, 1) == 1;
            i_w   = 16'($urandom);
            ext_w = 16'($urandom);
            ext_w_en = t_w;
            #1;
            checkOutput("rand_comb_bus", {8'h00, bus_c}, {8'h00, t_c ? ext_c : i_c});
            checkOutput("rand_comb_o",   {8'h00, o_c},   {8'h00, t_c ? ext_c : i_c});
            checkOutput("rand_input_o",  {8'h00, o_n},   {8'h00, ext_n});
            checkOutput("rand_output_o", {8'h00, o_o},   {8'h00, i_c});
            checkOutput("rand_wide_o",   o_w,            t_w ? ext_w : i_w);
            #4;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trellis_bidir_io.md
Name: trellis_bidir_io

Overview:
- Parameterised bidirectional pad cell modelled on the ECP5 TRELLIS_IO primitive, WIDTH bits wide, with one shared tri-state control.
- Sits between a synchronous controller (e.g. the FT2232 FIFO engine) and an external bidirectional data bus.
- Default configuration is purely combinational, so it is a drop-in for the primitive.
- Optional registered input capture and output/enable registers run on one clock with synchronous active-high reset.

Parameters:
- DIR, "BIDIR", pad mode: "INPUT", "OUTPUT" or "BIDIR"; any other value is an elaboration error.
- WIDTH, 8, number of pad bits.
- IN_REG, 0, 1 = O is taken from a register that samples B on clk_i; 0 = O is combinational from B.
- OUT_REG, 0, 1 = I and T are registered on clk_i before they reach the pad; 0 = combinational.

Ports:
- clk_i  input  1  clock; used only when IN_REG or OUT_REG = 1.
- reset_i  input  1  synchronous, active-high reset.
- B  inout  WIDTH  external pad bus.
- T  input  1  tri-state control: 1 = pad is an input (B released to Z); 0 = pad drives I onto B.
- I  input  WIDTH  data to drive onto B.
- O  output  WIDTH  data received from B.

Behaviour:
Effective controls:
- t_eff = T when OUT_REG = 0; otherwise t_q, a register loaded with T on each rising clk_i.
- i_eff = I when OUT_REG = 0; otherwise i_q, a register loaded with I on each rising clk_i.
- One cycle of latency applies from T/I to the pad when OUT_REG = 1.

Pad drive:
- DIR = "BIDIR": B = i_eff when t_eff = 0; B = all Z when t_eff = 1.
- DIR = "OUTPUT": B = i_eff at all times; T is ignored.
- DIR = "INPUT": B = all Z at all times; T and I are ignored.

Receive path:
- O reflects the pad value B in every mode. When the cell is driving, this includes loopback of its own drive.
- IN_REG = 0: O = B combinationally, with zero latency.
- IN_REG = 1: o_q samples B on rising clk_i and O = o_q, giving one cycle of latency.
- No pull-up or keeper: an undriven bus with t_eff = 1 propagates Z/X to O as-is.

Reset (synchronous, sampled on rising clk_i while reset_i = 1):
- t_q <= 1, so the pad is released to Z; the pad is never driven during or immediately after reset.
- i_q <= 0.
- o_q <= 0.
- While reset_i is held, registered paths keep these values and ignore T, I and B.
- With IN_REG = OUT_REG = 0, reset_i has no effect; the cell is combinational.
- Reset asserted mid-drive: B goes to Z at the first rising edge with reset_i = 1 (registered mode); immediately follows T (combinational mode).

Turnaround and other boundaries:
- T 0->1: the cell releases B in the same cycle (combinational) or next edge (OUT_REG).
- T 1->0: the cell drives i_eff in the same cycle (combinational) or next edge (OUT_REG).
- The cell never inserts its own dead cycle; bus turnaround spacing is the controller's responsibility.
- T and I changing in the same cycle take effect together.
- All WIDTH bits share T; per-bit direction is not supported.

Test Plan:
- BIDIR, comb, T=0, I=8'hA5 -> B=8'hA5 and O=8'hA5 in the same delta; T=1 with external 8'h3C on B -> B=8'h3C, O=8'h3C, cell output Z.
- BIDIR, OUT_REG=1, IN_REG=1: assert reset_i for 2 cycles -> B=Z, O=8'h00. Release, set T=0, I=8'h5A -> B=8'h5A after 1 edge, O=8'h5A after 2 edges.
- Turnaround, OUT_REG=1: drive 8'hFF with T=0, then T=1 with external 8'h11 applied one cycle later -> no contention; B=8'h11 one edge after T rises.
- Reset mid-drive, OUT_REG=1: T=0, I=8'hC3, then reset_i=1 -> B=Z at next edge and stays Z until reset_i=0 and T=0.
- DIR="INPUT", T=0, I=8'hAA, external 8'h0F -> B=8'h0F, O=8'h0F. DIR="OUTPUT", T=1, I=8'h81 -> B=8'h81.
- WIDTH=16, comb, T=0, I=16'hBEEF -> B=16'hBEEF and O=16'hBEEF.
